// File: rtl/seg_scan_display.sv
// Scans a 32-bit snapshot of data_i as 8 hex digits onto a common-anode 7-segment display.
// The snapshot refreshes once per scan frame, so a single frame never mixes two values.
module seg_scan_display #(
   parameter int SCAN_DIV = 20000,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic [31:0] data_i,
   input  logic        freeze_i,
   output logic [7:0]  led_en_o,
   output logic [7:0]  led_seg_o,
   output logic        frame_o
);

   localparam int               CNT_W   = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0] div_cnt;
   logic [2:0]       digit_idx;
   logic [31:0]      shadow;
   logic             tick;
   logic             wrap;
   logic [3:0]       nibble;
   logic             blank;
   logic [7:0]       en_nxt;
   logic [7:0]       seg_nxt;

   function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
      case (nib)
         4'h0:    hex_to_seg = 8'hC0;
         4'h1:    hex_to_seg = 8'hF9;
         4'h2:    hex_to_seg = 8'hA4;
         4'h3:    hex_to_seg = 8'hB0;
         4'h4:    hex_to_seg = 8'h99;
         4'h5:    hex_to_seg = 8'h92;
         4'h6:    hex_to_seg = 8'h82;
         4'h7:    hex_to_seg = 8'hF8;
         4'h8:    hex_to_seg = 8'h80;
         4'h9:    hex_to_seg = 8'h90;
         4'hA:    hex_to_seg = 8'h88;
         4'hB:    hex_to_seg = 8'h83;
         4'hC:    hex_to_seg = 8'hC6;
         4'hD:    hex_to_seg = 8'hA1;
         4'hE:    hex_to_seg = 8'h86;
         default: hex_to_seg = 8'h8E;
      endcase
   endfunction

   assign tick = (div_cnt == CNT_MAX);
   assign wrap = tick && (digit_idx == 3'd7);

   // NOTE: every signal assigned in always_comb gets a value on all paths
   // (defaults first, overrides after) so no latch is inferred.
   always_comb begin
      nibble  = shadow[{digit_idx, 2'b00} +: 4];
      en_nxt  = ~(8'b1 << digit_idx);
      seg_nxt = hex_to_seg(nibble);
      // A digit is a leading zero when it and everything above it is zero.
      blank   = BLANK_LZ && (digit_idx != 3'd0) &&
                ((shadow >> {digit_idx, 2'b00}) == 32'd0);
      if (blank) begin
         en_nxt  = 8'hFF;
         seg_nxt = 8'hFF;
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         div_cnt   <= '0;
         digit_idx <= '0;
         shadow    <= '0;
         led_en_o  <= 8'hFF;
         led_seg_o <= 8'hFF;
         frame_o   <= 1'b0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + CNT_W'(1);
         if (tick)
            digit_idx <= digit_idx + 3'd1;
         // Capture only at the frame boundary to avoid tearing.
         if (wrap && !freeze_i)
            shadow <= data_i;
         frame_o   <= wrap && !freeze_i;
         led_en_o  <= en_nxt;
         led_seg_o <= seg_nxt;
      end
   end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with SCAN_DIV=4 (32-cycle frames).
// A second instance with BLANK_LZ=0 shares all inputs.
module tb_seg_scan_display;

   localparam int SCAN_DIV = 4;

   localparam logic [7:0] EN_TAB [8]       = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
   localparam logic [7:0] SEG_1234ABCD [8] = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};
   localparam logic [7:0] SEG_12345678 [8] = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};

   logic        clk_i = 1'b0;
   logic        reset_n_i;
   logic [31:0] data_i;
   logic        freeze_i;
   logic [7:0]  led_en_o, led_seg_o;
   logic        frame_o;
   logic [7:0]  nb_en, nb_seg;
   logic        nb_frame;

   int n_checks = 0;
   int n_fail   = 0;

   seg_scan_display #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b1)) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .data_i(data_i), .freeze_i(freeze_i),
      .led_en_o(led_en_o), .led_seg_o(led_seg_o), .frame_o(frame_o)
   );

   seg_scan_display #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b0)) dut_nb (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .data_i(data_i), .freeze_i(freeze_i),
      .led_en_o(nb_en), .led_seg_o(nb_seg), .frame_o(nb_frame)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // One reset cycle; the next step() is edge 1 after release.
   task automatic do_reset(input logic [31:0] d);
      reset_n_i = 1'b0;
      data_i    = d;
      freeze_i  = 1'b0;
      step();
      reset_n_i = 1'b1;
   endtask

   task automatic test_reset();
      logic [15:0] exp;
      reset_n_i = 1'b0;
      data_i    = 32'hFFFF_FFFF;
      freeze_i  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if ({led_en_o, led_seg_o, frame_o} !== {16'hFFFF, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_out cyc=%0d got en=%h seg=%h frame=%b exp en=FF seg=FF frame=0",
                     i, led_en_o, led_seg_o, frame_o);
         end
      end
      reset_n_i = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         step();
         exp = (n <= 4) ? {8'hFE, 8'hC0} : 16'hFFFF;
         n_checks++;
         if ({led_en_o, led_seg_o} !== exp) begin
            n_fail++;
            $display("FAIL reset_shadow n=%0d got %h exp %h", n, {led_en_o, led_seg_o}, exp);
         end
      end
   endtask

   task automatic test_frame();
      int k;
      logic [15:0] exp;
      do_reset(32'h1234_ABCD);
      for (int n = 1; n <= 64; n++) begin
         step();
         k = ((n - 1) / 4) % 8;
         if (n <= 32) exp = (k == 0) ? {8'hFE, 8'hC0} : 16'hFFFF;
         else         exp = {EN_TAB[k], SEG_1234ABCD[k]};
         n_checks++;
         if (frame_o !== (n % 32 == 0)) begin
            n_fail++;
            $display("FAIL frame_pulse n=%0d got %b exp %b", n, frame_o, (n % 32 == 0));
         end
         n_checks++;
         if ({led_en_o, led_seg_o} !== exp) begin
            n_fail++;
            $display("FAIL frame_digit n=%0d got %h exp %h", n, {led_en_o, led_seg_o}, exp);
         end
      end
   endtask

   task automatic test_blank();
      int k;
      logic [15:0] exp, exp_nb;
      do_reset(32'h0000_00F0);
      for (int n = 1; n <= 64; n++) begin
         step();
         if (n >= 33) begin
            k      = (n - 33) / 4;
            exp    = (k == 0) ? {8'hFE, 8'hC0} : (k == 1) ? {8'hFD, 8'h8E} : 16'hFFFF;
            exp_nb = (k == 1) ? {8'hFD, 8'h8E} : {EN_TAB[k], 8'hC0};
            n_checks++;
            if ({led_en_o, led_seg_o} !== exp) begin
               n_fail++;
               $display("FAIL blank_f0 n=%0d got %h exp %h", n, {led_en_o, led_seg_o}, exp);
            end
            n_checks++;
            if ({nb_en, nb_seg} !== exp_nb) begin
               n_fail++;
               $display("FAIL noblank_f0 n=%0d got %h exp %h", n, {nb_en, nb_seg}, exp_nb);
            end
         end
      end
      do_reset(32'h0);
      for (int n = 1; n <= 32; n++) begin
         step();
         k      = (n - 1) / 4;
         exp    = (k == 0) ? {8'hFE, 8'hC0} : 16'hFFFF;
         exp_nb = {EN_TAB[k], 8'hC0};
         n_checks++;
         if ({led_en_o, led_seg_o} !== exp) begin
            n_fail++;
            $display("FAIL blank_zero n=%0d got %h exp %h", n, {led_en_o, led_seg_o}, exp);
         end
         n_checks++;
         if ({nb_en, nb_seg} !== exp_nb) begin
            n_fail++;
            $display("FAIL noblank_zero n=%0d got %h exp %h", n, {nb_en, nb_seg}, exp_nb);
         end
      end
   endtask

   task automatic test_freeze();
      int k;
      do_reset(32'h5);
      repeat (32) step();
      n_checks++;
      if (frame_o !== 1'b1) begin
         n_fail++;
         $display("FAIL freeze_capture got frame=%b exp 1", frame_o);
      end
      freeze_i = 1'b1;
      data_i   = 32'h7;
      for (int n = 33; n <= 96; n++) begin
         step();
         k = ((n - 1) / 4) % 8;
         n_checks++;
         if (frame_o !== 1'b0) begin
            n_fail++;
            $display("FAIL freeze_pulse n=%0d got %b exp 0", n, frame_o);
         end
         if (k == 0) begin
            n_checks++;
            if ({led_en_o, led_seg_o} !== {8'hFE, 8'h92}) begin
               n_fail++;
               $display("FAIL freeze_hold n=%0d got %h exp FE92", n, {led_en_o, led_seg_o});
            end
         end
      end
      freeze_i = 1'b0;
      for (int n = 97; n <= 132; n++) begin
         step();
         n_checks++;
         if (frame_o !== (n == 128)) begin
            n_fail++;
            $display("FAIL unfreeze_pulse n=%0d got %b exp %b", n, frame_o, (n == 128));
         end
         if (n >= 129) begin
            n_checks++;
            if ({led_en_o, led_seg_o} !== {8'hFE, 8'hF8}) begin
               n_fail++;
               $display("FAIL unfreeze_digit n=%0d got %h exp FEF8", n, {led_en_o, led_seg_o});
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      logic [15:0] exp;
      do_reset(32'h0050_0000);
      for (int n = 1; n <= 54; n++) begin
         step();
         if (n >= 53) begin
            n_checks++;
            if ({led_en_o, led_seg_o} !== {8'hDF, 8'h92}) begin
               n_fail++;
               $display("FAIL midrst_digit5 n=%0d got %h exp DF92", n, {led_en_o, led_seg_o});
            end
         end
      end
      reset_n_i = 1'b0;
      step();
      n_checks++;
      if ({led_en_o, led_seg_o, frame_o} !== {16'hFFFF, 1'b0}) begin
         n_fail++;
         $display("FAIL midrst_out got en=%h seg=%h frame=%b exp FF FF 0", led_en_o, led_seg_o, frame_o);
      end
      reset_n_i = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         step();
         exp = (n <= 4) ? {8'hFE, 8'hC0} : 16'hFFFF;
         n_checks++;
         if ({led_en_o, led_seg_o} !== exp) begin
            n_fail++;
            $display("FAIL midrst_restart n=%0d got %h exp %h", n, {led_en_o, led_seg_o}, exp);
         end
      end
   endtask

   task automatic test_no_tearing();
      int k;
      logic [15:0] exp;
      do_reset(32'hAAAA_AAAA);
      repeat (32) step();
      for (int n = 33; n <= 96; n++) begin
         step();
         data_i = n[0] ? 32'h1234_5678 : 32'h8765_4321;
         k = ((n - 1) / 4) % 8;
         exp = (n <= 64) ? {EN_TAB[k], 8'h88} : {EN_TAB[k], SEG_12345678[k]};
         n_checks++;
         if (frame_o !== (n == 64 || n == 96)) begin
            n_fail++;
            $display("FAIL tear_pulse n=%0d got %b exp %b", n, frame_o, (n == 64 || n == 96));
         end
         n_checks++;
         if ({led_en_o, led_seg_o} !== exp) begin
            n_fail++;
            $display("FAIL tear_digit n=%0d got %h exp %h", n, {led_en_o, led_seg_o}, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_blank();
      test_freeze();
      test_mid_reset();
      test_no_tearing();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
